// File: rtl/inv_add_round_key_stage_pkg.sv
// Shared constants and types for the inverse AddRoundKey stage.
package inv_add_round_key_stage_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_NR_128  = 10;

  typedef logic [3:0] round_idx_t;

  // InvMixColumns follows every middle round, never the first or final one
  function automatic logic mix_en_for(round_idx_t r, round_idx_t nr);
    return (r != 4'd0) && (r < nr);
  endfunction

endpackage

// File: rtl/inv_add_round_key_stage_if.sv
// Upstream state stream and downstream keyed-state stream of the stage.
interface inv_add_round_key_stage_if;
  import inv_add_round_key_stage_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_STATE_W-1:0] in_data;
  round_idx_t             in_round;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] out_data;
  logic                   out_mix_en;
  logic                   out_last;

  modport slave (
    input  in_valid, in_data, in_round, out_ready,
    output in_ready, out_valid, out_data, out_mix_en, out_last
  );

  modport master (
    output in_valid, in_data, in_round, out_ready,
    input  in_ready, out_valid, out_data, out_mix_en, out_last
  );
endinterface

// File: rtl/aes_skid_reg.sv
// Output register plus one-entry skid buffer; in_ready depends only on local state.
module aes_skid_reg #(
  parameter int W = 130
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic         skid_full_q, skid_full_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         out_fire;
  logic         push;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    out_fire    = out_valid_q && out_ready;
    push        = in_valid && !skid_full_q;

    if (skid_full_q) begin
      if (out_fire) begin
        out_data_d  = skid_data_q;
        skid_full_d = 1'b0;
      end
    end else if (push) begin
      // empty or draining output register takes the new state directly
      if (!out_valid_q || out_fire) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end else begin
        skid_data_d = in_data;
        skid_full_d = 1'b1;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      skid_full_q <= skid_full_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready  = !skid_full_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/inv_add_round_key_stage.sv
// Inverse-cipher AddRoundKey: XORs the state with a stored round key and tags
// whether InvMixColumns follows and whether this was the final round.
module inv_add_round_key_stage
  import inv_add_round_key_stage_pkg::*;
#(
  parameter int NR = AES_NR_128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_we,
  input  round_idx_t             key_idx,
  input  logic [AES_STATE_W-1:0] key_data,
  inv_add_round_key_stage_if.slave s,
  output logic                   err_bad_round
);

  localparam round_idx_t NR_IDX = round_idx_t'(NR);
  localparam int PAYLOAD_W = AES_STATE_W + 2;

  logic [AES_STATE_W-1:0] key_q [NR+1];
  logic [AES_STATE_W-1:0] key_d [NR+1];
  logic                   err_bad_round_q, err_bad_round_d;
  logic [AES_STATE_W-1:0] rd_key;
  logic                   round_ok;
  logic                   skid_in_ready;
  logic [PAYLOAD_W-1:0]   in_payload;
  logic [PAYLOAD_W-1:0]   out_payload;

  // key read sees pre-edge contents, so a same-cycle write applies from the next state
  always_comb begin
    key_d = key_q;
    if (key_we && (key_idx <= NR_IDX)) key_d[key_idx] = key_data;
  end

  always_comb begin
    round_ok        = (s.in_round <= NR_IDX);
    rd_key          = round_ok ? key_q[s.in_round] : '0;
    in_payload      = {mix_en_for(s.in_round, NR_IDX), (s.in_round == 4'd0),
                       s.in_data ^ rd_key};
    err_bad_round_d = err_bad_round_q | (s.in_valid && skid_in_ready && !round_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) key_q[i] <= '0;
      err_bad_round_q <= 1'b0;
    end else begin
      key_q           <= key_d;
      err_bad_round_q <= err_bad_round_d;
    end
  end

  // bad-round states are accepted (ready is shared) but never pushed
  aes_skid_reg #(.W(PAYLOAD_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s.in_valid && round_ok),
    .in_ready  (skid_in_ready),
    .in_data   (in_payload),
    .out_valid (s.out_valid),
    .out_ready (s.out_ready),
    .out_data  (out_payload)
  );

  assign s.in_ready    = skid_in_ready;
  assign s.out_mix_en  = out_payload[PAYLOAD_W-1];
  assign s.out_last    = out_payload[PAYLOAD_W-2];
  assign s.out_data    = out_payload[AES_STATE_W-1:0];
  assign err_bad_round = err_bad_round_q;

endmodule

// File: tb/tb_inv_add_round_key_stage.sv
// Directed-vector bench for inv_add_round_key_stage.
module tb_inv_add_round_key_stage;
  import inv_add_round_key_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_we;
  logic [3:0]   key_idx;
  logic [127:0] key_data;
  logic         err_bad_round;
  int checks = 0;
  int errors = 0;

  inv_add_round_key_stage_if bus ();

  inv_add_round_key_stage #(.NR(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_we        (key_we),
    .key_idx       (key_idx),
    .key_data      (key_data),
    .s             (bus),
    .err_bad_round (err_bad_round)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [3:0] idx, input logic [127:0] k);
    key_we = 1'b1; key_idx = idx; key_data = k;
    tick();
    key_we = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic [127:0] exp_d,
                         input logic exp_mix, input logic exp_last);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d ||
        bus.out_mix_en !== exp_mix || bus.out_last !== exp_last) begin
      errors++;
      $display("FAIL %s: got v=%b d=%h mix=%b last=%b, want v=1 d=%h mix=%b last=%b",
               name, bus.out_valid, bus.out_data, bus.out_mix_en, bus.out_last,
               exp_d, exp_mix, exp_last);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key_we = 1'b0; key_idx = '0; key_data = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_round = '0; bus.out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || err_bad_round !== 1'b0 ||
        bus.out_data !== 128'h0 || bus.out_mix_en !== 1'b0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset: got v=%b rdy=%b err=%b d=%h mix=%b last=%b, want 0 1 0 0 0 0",
               bus.out_valid, bus.in_ready, err_bad_round, bus.out_data,
               bus.out_mix_en, bus.out_last);
    end
  endtask

  task automatic test_vector();
    load_key(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    bus.in_valid = 1'b1; bus.in_round = 4'd0;
    bus.in_data  = 128'h00112233445566778899aabbccddeeff;
    tick();
    bus.in_valid = 1'b0;
    chk_out("known_vector", 128'h00102030405060708090a0b0c0d0e0f0, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL vector_drain: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d1 = 128'h0123456789abcdef0123456789abcdef;
    logic [127:0] d2 = 128'hffeeddccbbaa99887766554433221100;
    logic [127:0] d3 = 128'h0f0e0d0c0b0a09080706050403020100;
    load_key(4'd10, {16{8'ha0}});
    load_key(4'd5,  {16{8'h55}});
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_round = 4'd10; bus.in_data = d1;
    tick();
    chk_out("b2b_round10", d1 ^ {16{8'ha0}}, 1'b0, 1'b0);
    bus.in_round = 4'd5; bus.in_data = d2;
    tick();
    chk_out("b2b_round5", d2 ^ {16{8'h55}}, 1'b1, 1'b0);
    bus.in_round = 4'd0; bus.in_data = d3;
    tick();
    bus.in_valid = 1'b0;
    chk_out("b2b_round0", 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_stall();
    logic [127:0] a = 128'h11111111111111111111111111111111;
    logic [127:0] b = 128'h22222222222222222222222222222222;
    logic [127:0] c = 128'h33333333333333333333333333333333;
    load_key(4'd9, {16{8'h0f}});
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_round = 4'd9; bus.in_data = a;
    tick();
    chk_out("stall_a_out", a ^ {16{8'h0f}}, 1'b1, 1'b0);
    bus.in_data = b;
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready_drop: in_ready=%b want 0", bus.in_ready);
    end
    bus.in_data = c;
    tick();
    chk_out("stall_a_held", a ^ {16{8'h0f}}, 1'b1, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready_low: in_ready=%b want 0", bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();
    chk_out("stall_b_out", b ^ {16{8'h0f}}, 1'b1, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_ready_rise: in_ready=%b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    chk_out("stall_c_out", c ^ {16{8'h0f}}, 1'b1, 1'b0);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_collision();
    logic [127:0] x = 128'hdeadbeefcafef00d0123456789abcdef;
    load_key(4'd3, {16{8'h33}});
    bus.out_ready = 1'b1;
    key_we = 1'b1; key_idx = 4'd3; key_data = {16{8'hc3}};
    bus.in_valid = 1'b1; bus.in_round = 4'd3; bus.in_data = x;
    tick();
    key_we = 1'b0;
    chk_out("collision_old_key", x ^ {16{8'h33}}, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk_out("collision_new_key", x ^ {16{8'hc3}}, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_bad_round_and_reset();
    logic [127:0] y = 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_round = 4'd12; bus.in_data = y;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || err_bad_round !== 1'b1) begin
      errors++;
      $display("FAIL bad_round: out_valid=%b err=%b, want 0 1", bus.out_valid, err_bad_round);
    end
    tick();
    checks++;
    if (err_bad_round !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_round_sticky: err=%b v=%b, want 1 0", err_bad_round, bus.out_valid);
    end
    // fill output and skid, then reset mid-stall with competing key write and input
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_round = 4'd5;
    tick(); tick();
    rst = 1'b1; key_we = 1'b1; key_idx = 4'd0; key_data = {16{8'hff}};
    tick();
    rst = 1'b0; key_we = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    checks++;
    if (err_bad_round !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_midstall: err=%b v=%b rdy=%b, want 0 0 1",
               err_bad_round, bus.out_valid, bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.in_round = 4'd0; bus.in_data = y;
    tick();
    chk_out("key0_cleared", y, 1'b0, 1'b1);
    bus.in_round = 4'd5;
    tick();
    chk_out("key5_cleared", y, 1'b1, 1'b0);
    bus.in_round = 4'd10;
    tick();
    bus.in_valid = 1'b0;
    chk_out("key10_cleared", y, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    test_vector();
    test_back_to_back();
    test_stall();
    test_collision();
    test_bad_round_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_add_round_key_stage.md
INV_ADD_ROUND_KEY_STAGE -- requirements
Module: inv_add_round_key_stage

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the cipher round count; the key store depth is NR+1.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning a synchronous, active-high reset.
REQ-004 SHALL have port key_we  input  1  meaning a round-key write strobe.
REQ-005 SHALL have port key_idx  input  4  meaning the round-key index to write.
REQ-006 SHALL have port key_data  input  128  meaning the round-key value, byte 0 in bits [127:120].
REQ-007 SHALL have port in_valid  input  1  meaning upstream state valid.
REQ-008 SHALL have port in_ready  output  1  meaning the stage can accept a state.
REQ-009 SHALL have port in_data  input  128  meaning the state to be keyed, byte 0 in bits [127:120].
REQ-010 SHALL have port in_round  input  4  meaning the round index whose key is applied.
REQ-011 SHALL have port out_valid  output  1  meaning the output state is valid.
REQ-012 SHALL have port out_ready  input  1  meaning the downstream (InvMixColumns) stage accepts.
REQ-013 SHALL have port out_data  output  128  meaning in_data XOR key[in_round].
REQ-014 SHALL have port out_mix_en  output  1  meaning the downstream stage applies InvMixColumns; high iff round is in 1..NR-1.
REQ-015 SHALL have port out_last  output  1  meaning round 0 (final AddRoundKey, result is plaintext).
REQ-016 SHALL have port err_bad_round  output  1  meaning sticky flag: an in_round greater than NR was seen.

Function
REQ-017 Key store: NR+1 x 128-bit registers; written on key_we when key_idx<=NR; writes with key_idx>NR are ignored.
REQ-018 Acceptance: a transfer occurs on a cycle where in_valid&&in_ready; the output transfer occurs on out_valid&&out_ready.
REQ-019 Datapath: out_data = in_data ^ key[in_round]; out_mix_en and out_last are computed from in_round and registered alongside out_data.
REQ-020 Latency: exactly 1 cycle from acceptance to out_valid when the output register is empty or draining.
REQ-021 Buffering: an output register plus a one-entry skid register; in_ready = !skid_full, registered, with no combinational path from out_ready.
REQ-022 Stall: when out_valid&&!out_ready, out_data, out_mix_en and out_last are held stable; a new acceptance fills the skid register.
REQ-023 Drain: on an output transfer with the skid register full, the skid contents move to the output register on that edge and in_ready rises on the next cycle.
REQ-024 Ordering: strict FIFO order; no state is dropped or duplicated under any valid/ready pattern.
REQ-025 Write/read collision: key_we to index r on the same cycle as acceptance with in_round=r uses the old key; the new key applies from the next acceptance.
REQ-026 Bad round: a state accepted with in_round>NR is consumed, produces no output, and sets err_bad_round.
REQ-027 Simultaneous accept and output transfer with an empty skid register: the new state enters the output register directly, giving full 1-per-cycle throughput.

Reset
REQ-028 rst SHALL clear out_valid, the skid-full flag, err_bad_round, out_data, out_mix_en, out_last and all key registers to 0, and set in_ready to 1 on the cycle after rst.
REQ-029 rst asserted mid-stall SHALL discard the buffered states; no out_valid appears until a new acceptance.
REQ-030 rst SHALL take priority over key_we and in_valid in the same cycle.

Structure
REQ-031 The shared package SHALL hold the AES_STATE_W=128 and AES_NR_128=10 constants and a round-index type.
REQ-032 The skid/output register pair SHALL be one sub-module, aes_skid_reg, parameterised by payload width (130 bits here).

Verification
REQ-033 Load key[0]=000102030405060708090a0b0c0d0e0f; send 00112233445566778899aabbccddeeff with round 0 -> next cycle out_data=00102030405060708090a0b0c0d0e0f0, out_last=1, out_mix_en=0.
REQ-034 Rounds 10, 5 and 0 sent back-to-back with out_ready=1 -> three outputs on consecutive cycles with out_mix_en = 0, 1, 0 respectively.
REQ-035 Hold out_ready=0 and offer 3 states -> 2 are accepted and in_ready drops; release out_ready -> outputs appear in order, none lost.
REQ-036 key_we to idx 3 on the same cycle as accepting round 3 -> old key used; the next round-3 state uses the new key.
REQ-037 Send in_round=12 -> no out_valid and err_bad_round=1; assert rst -> err_bad_round=0 and all keys read as 0.
